// File: rtl/pulse_pkg.sv
// pulse_pkg: shared states, widths and default timeouts for the pulse id scheduler
package pulse_pkg;
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_B      = 3'd1,
    WAIT_RESULT = 3'd2,
    REARM       = 3'd3,
    ABORT       = 3'd4
  } state_t;
  localparam int DATA_W = 17;
  localparam int TS_W = 24;
  localparam int TIMER_W = 18;
  localparam int PAIR_TIMEOUT_DEF = 100000;
  localparam int RESULT_TIMEOUT_DEF = 200000;
endpackage

// File: rtl/pulse_id_scheduler_if.sv
// pulse_id_scheduler_if: decoder bank, identifier and result consumer signals
interface pulse_id_scheduler_if import pulse_pkg::*; #(
  parameter int NUM_SENSORS = 4,
  parameter int SEL_W = 2
);
  logic [NUM_SENSORS-1:0] dec_avail, dec_reset;
  logic [DATA_W*NUM_SENSORS-1:0] dec_data;
  logic [TS_W*NUM_SENSORS-1:0] dec_ts;
  logic id_avail0, id_avail1, id_consume0, id_consume1, id_ready, id_reset;
  logic [DATA_W-1:0] id_data0, id_data1, id_pulse0, id_pulse1, id_poly;
  logic [TS_W-1:0] id_ts0, id_ts1;
  logic res_valid, res_ack;
  logic [SEL_W-1:0] res_sensor0, res_sensor1;
  logic [DATA_W-1:0] res_pulse0, res_pulse1, res_poly;
  logic [7:0] drop_count;
  modport master (
    input dec_avail, dec_data, dec_ts, id_consume0, id_consume1, id_ready,
          id_pulse0, id_pulse1, id_poly, res_ack,
    output dec_reset, id_avail0, id_avail1, id_data0, id_data1, id_ts0, id_ts1,
           id_reset, res_valid, res_sensor0, res_sensor1, res_pulse0, res_pulse1,
           res_poly, drop_count
  );
  modport slave (
    output dec_avail, dec_data, dec_ts, id_consume0, id_consume1, id_ready,
           id_pulse0, id_pulse1, id_poly, res_ack,
    input dec_reset, id_avail0, id_avail1, id_data0, id_data1, id_ts0, id_ts1,
          id_reset, res_valid, res_sensor0, res_sensor1, res_pulse0, res_pulse1,
          res_poly, drop_count
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: first unmasked requester at or after ptr, with wrap
module rr_arbiter #(
  parameter int N = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [N-1:0]     excl,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] idx,
  output logic             any
);
  logic [N-1:0] m;
  assign m = req & ~excl;
  assign any = |m;
  assign gnt = any ? N'(1) << idx : '0;
  // scan downward from the farthest offset so the nearest requester wins
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--)
      idx = m[(int'(ptr) + k) % N] ? SEL_W'((int'(ptr) + k) % N) : idx;
  end
endmodule

// File: rtl/pulse_id_scheduler.sv
// pulse_id_scheduler: pairs pending decoder words onto one shared pulse identifier
module pulse_id_scheduler import pulse_pkg::*; #(
  parameter int NUM_SENSORS = 4,
  parameter int SEL_W = 2,
  parameter int PAIR_TIMEOUT = PAIR_TIMEOUT_DEF,
  parameter int RESULT_TIMEOUT = RESULT_TIMEOUT_DEF
) (
  input logic clk_96MHz,
  input logic reset,
  pulse_id_scheduler_if.master bus
);
  localparam logic [TIMER_W-1:0] PAIR_LIM = TIMER_W'(PAIR_TIMEOUT);
  localparam logic [TIMER_W-1:0] RESULT_LIM = TIMER_W'(RESULT_TIMEOUT);
  state_t state, next_state;
  logic [SEL_W-1:0] sel0, sel1, rr_ptr, idx_a, idx_b;
  logic [NUM_SENSORS-1:0] req, gnt_a, gnt_b, mask0, mask1;
  logic [TIMER_W-1:0] timer;
  logic any_a, any_b, grant_a, grant_b, capture, flush;
  function automatic logic [SEL_W-1:0] after(input logic [SEL_W-1:0] i);
    return (int'(i) == NUM_SENSORS - 1) ? '0 : i + 1'b1;
  endfunction
  // a sensor whose clear is in flight still shows avail for one cycle; hide it
  assign req = bus.dec_avail & ~bus.dec_reset;
  assign flush = state == REARM || state == ABORT;
  assign bus.id_data0 = bus.dec_data[sel0*DATA_W +: DATA_W];
  assign bus.id_data1 = bus.dec_data[sel1*DATA_W +: DATA_W];
  assign bus.id_ts0 = bus.dec_ts[sel0*TS_W +: TS_W];
  assign bus.id_ts1 = bus.dec_ts[sel1*TS_W +: TS_W];
  rr_arbiter #(.N(NUM_SENSORS), .SEL_W(SEL_W)) arb_a (
    .req(req), .ptr(rr_ptr), .excl('0), .gnt(gnt_a), .idx(idx_a), .any(any_a)
  );
  rr_arbiter #(.N(NUM_SENSORS), .SEL_W(SEL_W)) arb_b (
    .req(req), .ptr(rr_ptr), .excl(mask0), .gnt(gnt_b), .idx(idx_b), .any(any_b)
  );
  // state register
  always_ff @(posedge clk_96MHz)
    state <= reset ? IDLE : next_state;
  // next state and the per-cycle grant/capture strobes
  always_comb begin
    next_state = state;
    grant_a = 1'b0;
    grant_b = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        grant_a = any_a;
        next_state = any_a ? WAIT_B : IDLE;
      end
      WAIT_B: begin
        grant_b = any_b;
        next_state = any_b ? WAIT_RESULT : (timer >= PAIR_LIM ? ABORT : WAIT_B);
      end
      WAIT_RESULT: begin
        capture = bus.id_ready && !bus.res_valid;
        next_state = capture ? REARM : (timer >= RESULT_LIM ? ABORT : WAIT_RESULT);
      end
      default: next_state = IDLE;
    endcase
  end
  // slot ownership, decoder clears, result capture and the drop counter
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      sel0 <= '0;
      sel1 <= '0;
      mask0 <= '0;
      mask1 <= '0;
      rr_ptr <= '0;
      timer <= '0;
      bus.id_avail0 <= 1'b0;
      bus.id_avail1 <= 1'b0;
      bus.dec_reset <= '0;
      bus.id_reset <= state != IDLE;
      bus.res_valid <= 1'b0;
      bus.res_sensor0 <= '0;
      bus.res_sensor1 <= '0;
      bus.res_pulse0 <= '0;
      bus.res_pulse1 <= '0;
      bus.res_poly <= '0;
      bus.drop_count <= '0;
    end else begin
      timer <= (grant_a || grant_b) ? '0 : (&timer ? timer : timer + 1'b1);
      bus.id_reset <= flush;
      bus.dec_reset <= (bus.id_avail0 && (bus.id_consume0 || state == ABORT) ? mask0 : '0)
                     | (bus.id_avail1 && (bus.id_consume1 || state == ABORT) ? mask1 : '0);
      bus.id_avail0 <= grant_a || (bus.id_avail0 && !bus.id_consume0 && !flush);
      bus.id_avail1 <= grant_b || (bus.id_avail1 && !bus.id_consume1 && !flush);
      if (grant_a) begin
        sel0 <= idx_a;
        mask0 <= gnt_a;
        rr_ptr <= after(idx_a);
      end
      if (grant_b) begin
        sel1 <= idx_b;
        mask1 <= gnt_b;
        rr_ptr <= after(idx_b);
      end
      bus.res_valid <= capture || (bus.res_valid && !bus.res_ack);
      if (capture) begin
        bus.res_sensor0 <= sel0;
        bus.res_sensor1 <= sel1;
        bus.res_pulse0 <= bus.id_pulse0;
        bus.res_pulse1 <= bus.id_pulse1;
        bus.res_poly <= bus.id_poly;
      end
      if (state == ABORT && bus.drop_count != 8'hFF)
        bus.drop_count <= bus.drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_pulse_id_scheduler.sv
// tb_pulse_id_scheduler: scoreboard bench for the shared pulse identifier scheduler
module tb_pulse_id_scheduler;
  import pulse_pkg::*;
  localparam int NS = 4;
  localparam int SW = 2;
  localparam int PT = 20;
  localparam int RT = 30;
  typedef struct packed {
    logic [1:0] s0, s1;
    logic [16:0] p0, p1, poly;
  } res_t;
  logic clk_96MHz = 1'b0;
  logic reset = 1'b1;
  res_t exp_res[$];
  logic [3:0] exp_dr[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_idrst = 0;
  logic prev_rv = 1'b0;
  always #5 clk_96MHz = ~clk_96MHz;
  pulse_id_scheduler_if #(.NUM_SENSORS(NS), .SEL_W(SW)) bus ();
  pulse_id_scheduler #(.NUM_SENSORS(NS), .SEL_W(SW), .PAIR_TIMEOUT(PT), .RESULT_TIMEOUT(RT)) dut (
    .clk_96MHz(clk_96MHz), .reset(reset), .bus(bus)
  );
  function automatic logic [16:0] dw(input int i);
    return 17'h1A000 + 17'(i * 3);
  endfunction
  function automatic logic [23:0] tw(input int i);
    return 24'hA00000 + 24'(i * 7);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    res_t r;
    @(negedge clk_96MHz);
    if (bus.dec_reset != '0) begin
      if (exp_dr.size() == 0) check("dec_reset_unexpected", 32'(bus.dec_reset), 32'd0);
      else check("dec_reset_sb", 32'(bus.dec_reset), 32'(exp_dr.pop_front()));
    end
    if (bus.id_reset) n_idrst++;
    if (bus.res_valid && !prev_rv) begin
      if (exp_res.size() == 0) check("res_unexpected", 32'(bus.res_valid), 32'd0);
      else begin
        r = exp_res.pop_front();
        check("res_sensor0", 32'(bus.res_sensor0), 32'(r.s0));
        check("res_sensor1", 32'(bus.res_sensor1), 32'(r.s1));
        check("res_pulse0", 32'(bus.res_pulse0), 32'(r.p0));
        check("res_pulse1", 32'(bus.res_pulse1), 32'(r.p1));
        check("res_poly", 32'(bus.res_poly), 32'(r.poly));
      end
    end
    prev_rv = bus.res_valid;
    bus.dec_avail = bus.dec_avail & ~bus.dec_reset;
  endtask
  task automatic wait_slot(input int n);
    int k = 0;
    while (!(n == 1 ? bus.id_avail1 : bus.id_avail0) && k < 50) begin
      tick();
      k++;
    end
    check(n == 1 ? "slot1_up" : "slot0_up", 32'(n == 1 ? bus.id_avail1 : bus.id_avail0), 32'd1);
  endtask
  task automatic check_slots(input int s0, input int s1);
    check("id_data0", 32'(bus.id_data0), 32'(dw(s0)));
    check("id_ts0", 32'(bus.id_ts0), 32'(tw(s0)));
    check("id_data1", 32'(bus.id_data1), 32'(dw(s1)));
    check("id_ts1", 32'(bus.id_ts1), 32'(tw(s1)));
  endtask
  task automatic consume_both(input int s0, input int s1);
    bus.id_consume0 = 1'b1;
    exp_dr.push_back(4'(1 << s0));
    tick();
    bus.id_consume0 = 1'b0;
    check("consume0_dr", 32'(bus.dec_reset), 32'(1 << s0));
    check("slot0_drop", 32'(bus.id_avail0), 32'd0);
    bus.id_consume1 = 1'b1;
    exp_dr.push_back(4'(1 << s1));
    tick();
    bus.id_consume1 = 1'b0;
    check("consume1_dr", 32'(bus.dec_reset), 32'(1 << s1));
    check("slot1_drop", 32'(bus.id_avail1), 32'd0);
  endtask
  task automatic deliver(input int s0, input int s1, input logic [16:0] p0, input logic [16:0] p1,
                         input logic [16:0] poly, input bit ack);
    int k = 0;
    int n0;
    bus.id_pulse0 = p0;
    bus.id_pulse1 = p1;
    bus.id_poly = poly;
    bus.id_ready = 1'b1;
    exp_res.push_back(res_t'{s0: 2'(s0), s1: 2'(s1), p0: p0, p1: p1, poly: poly});
    n0 = n_idrst;
    tick();
    check("res_valid_up", 32'(bus.res_valid), 32'd1);
    while (!bus.id_reset && k < 10) begin
      tick();
      k++;
    end
    bus.id_ready = 1'b0;
    tick();
    check("rearm_pulses", 32'(n_idrst - n0), 32'd1);
    if (ack) begin
      bus.res_ack = 1'b1;
      tick();
      bus.res_ack = 1'b0;
      check("res_clear", 32'(bus.res_valid), 32'd0);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int k;
    int n0;
    bus.dec_avail = '0;
    bus.id_consume0 = 1'b0;
    bus.id_consume1 = 1'b0;
    bus.id_ready = 1'b0;
    bus.id_pulse0 = '0;
    bus.id_pulse1 = '0;
    bus.id_poly = '0;
    bus.res_ack = 1'b0;
    for (int i = 0; i < NS; i++) begin
      bus.dec_data[i*DATA_W +: DATA_W] = dw(i);
      bus.dec_ts[i*TS_W +: TS_W] = tw(i);
    end
    repeat (3) tick();
    check("rst_dec_reset", 32'(bus.dec_reset), 32'd0);
    check("rst_avail", 32'({bus.id_avail0, bus.id_avail1}), 32'd0);
    check("rst_id_reset", 32'(bus.id_reset), 32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_drop", 32'(bus.drop_count), 32'd0);
    reset = 1'b0;
    // sensor 0 alone, sensor 2 arrives ten cycles later
    bus.dec_avail = 4'b0001;
    wait_slot(0);
    check("t1_data0", 32'(bus.id_data0), 32'(dw(0)));
    repeat (10) tick();
    check("t1_no_self_pair", 32'(bus.id_avail1), 32'd0);
    bus.dec_avail = bus.dec_avail | 4'b0100;
    wait_slot(1);
    check_slots(0, 2);
    consume_both(0, 2);
    deliver(0, 2, 17'h00123, 17'h00456, 17'h000D3, 1'b1);
    // lone sensor 2 never finds a partner
    bus.dec_avail = 4'b0100;
    wait_slot(0);
    exp_dr.push_back(4'b0100);
    k = 0;
    while (!bus.id_reset && k < PT + 20) begin
      tick();
      k++;
    end
    check("abort_time", 32'(k >= PT && k <= PT + 3), 32'd1);
    check("abort_dr", 32'(bus.dec_reset), 32'b0100);
    check("abort_drop", 32'(bus.drop_count), 32'd1);
    check("abort_avail", 32'(bus.id_avail0), 32'd0);
    tick();
    // wrap: 3 then 0 leaves the pointer at 1
    bus.dec_avail = 4'b1000;
    wait_slot(0);
    bus.dec_avail = bus.dec_avail | 4'b0001;
    wait_slot(1);
    check_slots(3, 0);
    consume_both(3, 0);
    deliver(3, 0, 17'h0AAAA, 17'h05555, 17'h1F00F, 1'b1);
    // 0,1,3 pending with pointer 1 picks 1 then 3
    bus.dec_avail = 4'b1011;
    wait_slot(0);
    wait_slot(1);
    check_slots(1, 3);
    bus.dec_avail = bus.dec_avail | 4'b0100;
    consume_both(1, 3);
    deliver(1, 3, 17'h00777, 17'h00888, 17'h00999, 1'b1);
    // pointer back at 0 picks 0 over 2; result then left unacknowledged
    wait_slot(0);
    wait_slot(1);
    check_slots(0, 2);
    consume_both(0, 2);
    deliver(0, 2, 17'h00ABC, 17'h00DEF, 17'h00135, 1'b0);
    bus.dec_avail = 4'b0110;
    wait_slot(0);
    wait_slot(1);
    check_slots(1, 2);
    consume_both(1, 2);
    bus.id_pulse0 = 17'h1FFFF;
    bus.id_pulse1 = 17'h1EEEE;
    bus.id_poly = 17'h1DDDD;
    bus.id_ready = 1'b1;
    k = 0;
    while (!bus.id_reset && k < RT + 20) begin
      tick();
      k++;
    end
    bus.id_ready = 1'b0;
    check("stall_drop", 32'(bus.drop_count), 32'd2);
    check("stall_valid", 32'(bus.res_valid), 32'd1);
    check("stall_sensor1", 32'(bus.res_sensor1), 32'd2);
    check("stall_pulse0", 32'(bus.res_pulse0), 32'h00ABC);
    check("stall_poly", 32'(bus.res_poly), 32'h00135);
    tick();
    bus.res_ack = 1'b1;
    tick();
    bus.res_ack = 1'b0;
    check("stall_clear", 32'(bus.res_valid), 32'd0);
    // reset while waiting for a result
    bus.dec_avail = 4'b0011;
    wait_slot(0);
    wait_slot(1);
    check_slots(0, 1);
    consume_both(0, 1);
    reset = 1'b1;
    n0 = n_idrst;
    tick();
    reset = 1'b0;
    check("mid_rst_id_reset", 32'(bus.id_reset), 32'd1);
    check("mid_rst_avail", 32'({bus.id_avail0, bus.id_avail1}), 32'd0);
    check("mid_rst_dec_reset", 32'(bus.dec_reset), 32'd0);
    check("mid_rst_drop", 32'(bus.drop_count), 32'd0);
    check("mid_rst_res", 32'({bus.res_valid, bus.res_poly}), 32'd0);
    tick();
    check("mid_rst_pulses", 32'(n_idrst - n0), 32'd1);
    bus.dec_avail = 4'b1010;
    wait_slot(0);
    wait_slot(1);
    check_slots(1, 3);
    consume_both(1, 3);
    deliver(1, 3, 17'h00042, 17'h00024, 17'h00101, 1'b1);
    check("dr_queue_empty", 32'(exp_dr.size()), 32'd0);
    check("res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
